// File: rtl/debounce_sync_if.sv
// debounce_sync_if: raw button input, enable and conditioned level/pulse outputs of debounce_sync
interface debounce_sync_if;
   logic btn_in;
   logic enable;
   logic level_out;
   logic rise_pulse;
   logic fall_pulse;
   logic busy;
   modport master(output btn_in, enable, input level_out, rise_pulse, fall_pulse, busy);
   modport slave(input btn_in, enable, output level_out, rise_pulse, fall_pulse, busy);
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes a bouncy async input, commits a level after N identical samples, emits edge pulses
module debounce_sync #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter int   CNT_WIDTH       = 16,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input logic           clk,
   input logic           reset,
   debounce_sync_if.slave bus
);
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 ||
       longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_WIDTH) - 1) begin : g_bad_params
      $error("debounce_sync: illegal SYNC_STAGES/DEBOUNCE_CYCLES/CNT_WIDTH combination");
   end
   typedef enum logic {S_IDLE, S_WAIT} state_t;
   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   state_t                 state_q, state_d;
   logic                   level_q, level_d, rise_q, rise_d, fall_q, fall_d, s;
   assign s = sync_q[SYNC_STAGES-1];
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], bus.btn_in};
      state_d = state_q;
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (state_q == S_IDLE) begin
         if (bus.enable && s != level_q) begin
            state_d = S_WAIT;
            cnt_d   = CNT_WIDTH'(1);
         end
      end else if (!bus.enable || s == level_q) begin
         state_d = S_IDLE;
      end else if (cnt_q == LAST) begin
         state_d = S_IDLE;
         level_d = s;
         rise_d  = s;
         fall_d  = !s;
      end else begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
         state_q <= S_IDLE;
         cnt_q   <= '0;
         level_q <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end
   assign bus.level_out  = level_q;
   assign bus.rise_pulse = rise_q;
   assign bus.fall_pulse = fall_q;
   assign bus.busy       = state_q == S_WAIT;
endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw, asynchronous, bouncy input (push-button or switch) into a clean, clk-synchronous level plus single-cycle edge pulses.
- Sits directly upstream of the single-bit registered stage and drives its d input.
- Structure: multi-flop synchronizer, then a debounce counter/FSM, then registered level and edge outputs.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.
- DEBOUNCE_CYCLES, 50000, number of consecutive identical synchronized samples (N) required to commit a new level; legal range 2..2^CNT_WIDTH-1.
- CNT_WIDTH, 16, debounce counter width.
- RESET_LEVEL, 0, value loaded into the synchronizer flops and level_out on reset.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high reset.
- btn_in, input, 1, raw asynchronous input; sampled only by the first synchronizer flop.
- enable, input, 1, debounce enable; when low, no new level is committed.
- level_out, output, 1, debounced, registered level.
- rise_pulse, output, 1, one-cycle pulse when level_out commits 0->1.
- fall_pulse, output, 1, one-cycle pulse when level_out commits 1->0.
- busy, output, 1, high while a candidate change is being qualified (WAIT state).

Behaviour:
- Reset (synchronous, active-high, clock is clk):
  - All sync flops and level_out load RESET_LEVEL.
  - rise_pulse=0, fall_pulse=0, busy=0, counter=0, state=IDLE.
  - Reset overrides every other input in the same cycle.
- Synchronizer:
  - Shift chain of SYNC_STAGES flops; s = last flop.
  - No logic between the flops.
  - btn_in reaches s after SYNC_STAGES edges.
- FSM, 2 states, evaluated every edge when not in reset:
  - IDLE:
    - If enable=1 and s!=level_out: go to WAIT, counter<=1.
    - Otherwise stay in IDLE, counter<=0.
  - WAIT:
    - If enable=0: go to IDLE, counter<=0, level_out holds (abort).
    - Else if s==level_out: go to IDLE, counter<=0 (bounce rejected, no pulse).
    - Else if counter==DEBOUNCE_CYCLES-1: commit level_out<=s, go to IDLE, counter<=0.
    - Else counter<=counter+1.
- busy = (state==WAIT); registered via the state register.
- Pulses:
  - rise_pulse and fall_pulse are registered and assert in the same cycle level_out first shows the new value.
  - Each lasts exactly one cycle.
  - They are never both high, and never high without a level_out change.
- Latency: if btn_in changes before edge t0 and stays stable, level_out and the pulse update after edge t0+SYNC_STAGES+DEBOUNCE_CYCLES-1.
- Boundaries:
  - Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
  - A single-cycle disagreement in WAIT restarts qualification from zero.
  - enable falling in the same cycle as the commit condition aborts; no commit.
  - Reset mid-WAIT discards the candidate and produces no pulse.
  - Back-to-back toggles each need a full N-sample qualification; the minimum spacing between pulses is N+1 cycles.
- Elaboration-time check: SYNC_STAGES<2 or DEBOUNCE_CYCLES>2^CNT_WIDTH-1 is an error.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0, enable=1 unless stated.
1. Reset: reset=1 for 3 cycles with btn_in=1 -> level_out=0, rise_pulse=0, fall_pulse=0, busy=0 throughout, plus the first cycle after release.
2. Clean press: btn_in 0->1 before edge t0, held high -> busy=1 after t0+2; level_out=1 and rise_pulse=1 after t0+5; rise_pulse=0 and busy=0 after t0+6.
3. Bounce rejection: btn_in high for 3 cycles, then low, repeated 4 times -> level_out stays 0, no pulses, busy toggles, counter max 3.
4. Clean release from level_out=1: btn_in 1->0 before edge t0 -> level_out=0 with fall_pulse=1 for exactly one cycle after t0+5; rise_pulse stays 0.
5. Abort paths:
   - enable driven 0 at the cycle the counter reaches 3 -> no commit, busy=0 next cycle.
   - Repeat with reset=1 mid-WAIT -> level_out=0, no pulse.
6. Rapid legal toggling: btn_in toggles every 8 cycles for 64 cycles -> exactly 4 rise and 4 fall pulses, alternating, each 5 cycles after its btn_in edge.
